// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD <-> binary converter pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_bi_state_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Smallest binary width able to hold 10^digits - 1.
    function automatic int bcd_bin_width(input int digits);
        longint unsigned max_v;
        int              w;
        max_v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            max_v = max_v * 64'd10;
        end
        max_v = max_v - 64'd1;
        w = 1;
        for (int i = 1; i < 64; i++) begin
            if ((64'd1 << i) <= max_v) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step, with an out-of-range digit flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = 32
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] next_acc,
    output logic             digit_bad
);

    // Shift-and-add multiply by ten; bad digits still accumulate at raw value.
    always_comb begin
        next_acc  = (acc << 3) + (acc << 1) + BIN_W'(digit);
        digit_bad = (digit > BCD_DIGIT_MAX);
    end

endmodule

// File: rtl/bcd_bi.sv
// Sequential BCD-to-binary converter, one digit per cycle, MS digit first.
// Latency: DIGITS cycles from input accept to out_valid; DIGITS+2 cycles per word.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module bcd_bi
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  bin_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int SR_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Reject parameterisations that could silently overflow.
    if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
        $error("bcd_bi: DIGITS must be in 1..9");
    end
    if (BIN_W < bcd_bin_width(DIGITS)) begin : g_bad_width
        $error("bcd_bi: BIN_W too narrow for DIGITS");
    end

    bcd_bi_state_e    state_q, state_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [BIN_W-1:0] mac_acc;
    logic             mac_bad;

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .acc       (acc_q),
        .digit     (sr_q[SR_W-1 -: 4]),
        .next_acc  (mac_acc),
        .digit_bad (mac_bad)
    );

    // Next-state: load in IDLE, fold one digit per CONV cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = bcd_in;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = mac_acc;
                sr_d  = sr_q << 4;
                err_d = err_q | mac_bad;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode registered state only; an errored word reads as zero.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        bin_out   = (out_valid && !err_q) ? acc_q : '0;
        bin_err   = out_valid & err_q;
    end

endmodule

// File: doc/bcd_bi.md
# bcd_bi

Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD block. Accepts a packed unsigned BCD word through a valid/ready handshake. Converts it one decimal digit per clock, most significant digit first, using a multiply-by-10 accumulate. Presents the binary result with an invalid-digit flag through a second valid/ready handshake. It sits on the display/decimal-entry side of the datapath, where decimal operands re-enter binary arithmetic.

## Interface
- DIGITS, 8: number of BCD digits in the input word; legal range 1..9.
- BIN_W, 32: binary output width; must satisfy 2^BIN_W > 10^DIGITS - 1 (elaboration-time assertion).
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]. Sampled only on the input handshake.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bin_out  output  BIN_W  binary result, zero-extended; stable while out_valid is high.
- bin_err  output  1  at least one input nibble was greater than 9; qualified by out_valid.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture bcd_in into the digit shift register, clear acc, clear err, load digit counter cnt=DIGITS-1, and go to CONV.
- CONV, each cycle:
  - d = top nibble of the shift register.
  - acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d at BIN_W bits.
  - Shift register <= shift register << 4.
  - err <= err | (d > 9).
  - When cnt==0, go to DONE; otherwise decrement cnt.
- DONE:
  - out_valid=1.
  - bin_out = err ? 0 : acc.
  - bin_err = err.
  - When out_ready is high, go to IDLE.
- Arithmetic: all intermediate values are BIN_W bits. The width rule guarantees no overflow for valid input. Invalid nibbles are accumulated at their raw value (0xA..0xF), and the result is then forced to 0 at the output.
- No same-cycle handoff: the DONE→IDLE transition and the next input acceptance happen in separate cycles.
- Input holding: in_valid may stay high while in_ready is low. The block ignores bcd_in until IDLE.
- Reset values: in_ready=1 (state IDLE), out_valid=0, bin_out=0, bin_err=0, acc=0, cnt=0, shift register=0.
- Reset mid-operation: an asserted rst_n aborts any conversion immediately. The partial result is discarded and no out_valid pulse is produced.

## Timing
- Input handshake occurs at rising edge E0 (in_valid & in_ready).
- CONV occupies DIGITS cycles, spanning edges E0+1 through E0+DIGITS.
- out_valid rises after edge E0+DIGITS. Latency from accept to out_valid is DIGITS cycles.
- If out_ready is high on the first DONE cycle, out_valid is high for exactly 1 cycle and in_ready returns on the following cycle.
- Minimum throughput: one conversion per DIGITS+2 cycles.
- Backpressure: out_valid, bin_out and bin_err are held constant until out_ready is sampled high.
- in_ready, out_valid, bin_out and bin_err are decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg` contains:
  - state typedef bcd_bi_state_e {IDLE, CONV, DONE}
  - localparam BCD_DIGIT_MAX = 4'd9
  - function bcd_bin_width(digits), which returns the minimum BIN_W. It is used by the assertion and by the forward converter.
- Sub-module `bcd_mac10` holds the combinational acc*10+digit datapath, with input acc[BIN_W], input digit[4], output next_acc[BIN_W] and output digit_bad. The top level holds the FSM, counter, shift register and handshake.

## Test plan
- bcd_in=0x12345678 accepted with out_ready=1 → out_valid high 8 cycles after accept, bin_out=0x00BC614E, bin_err=0, pulse 1 cycle.
- bcd_in=0x99999999 → bin_out=0x05F5E0FF, bin_err=0; bcd_in=0x00000000 → bin_out=0, bin_err=0.
- bcd_in=0x0000001A (invalid units nibble) → bin_out=0, bin_err=1; then 0x00000042 → bin_out=42, bin_err=0 (err not sticky across words).
- Backpressure: bcd_in=0x00000255 with out_ready=0 for 5 cycles after out_valid → bin_out=255 stable, in_ready=0 throughout; next word is accepted no earlier than 1 cycle after the out_ready handshake.
- Reset mid-conversion: drop rst_n 3 cycles after accepting 0x87654321 → out_valid=0 and in_ready=1 immediately; no result appears after release; the following word 0x00000010 → bin_out=10.
- Back-to-back: in_valid held high with 4 successive words → each result correct and in order, spacing exactly DIGITS+2 cycles.
